// File: rtl/exc_sequencer_pkg.sv
// Shared types and defaults for the exception sequencer.
// Covers the exception codes, the FSM state type and the default fetch targets.
package exc_sequencer_pkg;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  // A zero code in the pipeline means "no exception"; interrupts reach us via cp0_irq only.
  localparam logic [4:0] EXC_NONE = 5'd0;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } st_e;

  localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;
  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;

endpackage

// File: rtl/exc_sequencer_if.sv
// Bundle between the pipeline/CP0 and the exception sequencer.
// slave = sequencer side, master = pipeline/CP0 side.
interface exc_sequencer_if;
  logic        m_valid;
  logic [31:0] m_pc;
  logic        m_is_slot;
  logic [4:0]  m_exc_code;
  logic        m_eret;
  logic        e_valid;
  logic [31:0] e_pc;
  logic        e_is_slot;
  logic [31:0] d_pc;
  logic        cp0_irq;
  logic [31:0] cp0_epc;
  logic [31:0] cp0_pc;
  logic        cp0_is_slot;
  logic [4:0]  cp0_exc_code;
  logic        cp0_eret;
  logic        flush_all;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [15:0] exc_count;

  modport slave (
    input  m_valid, m_pc, m_is_slot, m_exc_code, m_eret,
    input  e_valid, e_pc, e_is_slot, d_pc, cp0_irq, cp0_epc,
    output cp0_pc, cp0_is_slot, cp0_exc_code, cp0_eret,
    output flush_all, redirect_valid, redirect_pc, exc_count
  );

  modport master (
    output m_valid, m_pc, m_is_slot, m_exc_code, m_eret,
    output e_valid, e_pc, e_is_slot, d_pc, cp0_irq, cp0_epc,
    input  cp0_pc, cp0_is_slot, cp0_exc_code, cp0_eret,
    input  flush_all, redirect_valid, redirect_pc, exc_count
  );
endinterface

// File: rtl/exc_pc_picker.sv
// Macroscopic PC / delay-slot selection: the oldest real instruction in M, E or D,
// falling back to the reset PC until anything has reached D.
module exc_pc_picker #(
  parameter logic [31:0] RESET_PC = exc_sequencer_pkg::RESET_PC_DEF
) (
  input  logic        m_valid,
  input  logic [31:0] m_pc,
  input  logic        m_is_slot,
  input  logic        e_valid,
  input  logic [31:0] e_pc,
  input  logic        e_is_slot,
  input  logic        seen_d,
  input  logic [31:0] d_pc,
  output logic [31:0] pc,
  output logic        is_slot
);

  always_comb begin
    pc      = RESET_PC;
    is_slot = 1'b0;
    if (m_valid) begin
      pc      = m_pc;
      is_slot = m_is_slot;
    end else if (e_valid) begin
      pc      = e_pc;
      is_slot = e_is_slot;
    end else if (seen_d) begin
      pc      = d_pc;
    end
  end

endmodule

// File: rtl/exc_sequencer.sv
// M-stage exception/interrupt/eret sequencer: feeds CP0, turns its irq/epc into
// a flush plus fetch redirect, and holds the flush for FLUSH_CYCLES extra cycles.
module exc_sequencer
  import exc_sequencer_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC   = HANDLER_PC_DEF,
  parameter logic [31:0] RESET_PC     = RESET_PC_DEF,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  exc_sequencer_if.slave     bus
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  st_e              state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      exc_count_q, exc_count_d;
  logic             seen_d_q;
  logic             eret_raw;

  exc_pc_picker #(.RESET_PC(RESET_PC)) u_picker (
    .m_valid   (bus.m_valid),
    .m_pc      (bus.m_pc),
    .m_is_slot (bus.m_is_slot),
    .e_valid   (bus.e_valid),
    .e_pc      (bus.e_pc),
    .e_is_slot (bus.e_is_slot),
    .seen_d    (seen_d_q),
    .d_pc      (bus.d_pc),
    .pc        (bus.cp0_pc),
    .is_slot   (bus.cp0_is_slot)
  );

  // A faulting instruction never retires as eret.
  assign eret_raw = bus.m_valid & bus.m_eret & (bus.m_exc_code == EXC_NONE);

  always_comb begin
    state_d            = state_q;
    cnt_d              = cnt_q;
    exc_count_d        = exc_count_q;
    bus.cp0_exc_code   = 5'd0;
    bus.cp0_eret       = 1'b0;
    bus.flush_all      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = HANDLER_PC;
    unique case (state_q)
      RUN: begin
        bus.cp0_exc_code = bus.m_valid ? bus.m_exc_code : 5'd0;
        // Interrupt/exception entry outranks a simultaneous eret.
        bus.cp0_eret     = eret_raw & ~bus.cp0_irq;
        if (bus.cp0_irq) begin
          bus.flush_all      = 1'b1;
          bus.redirect_valid = 1'b1;
          state_d            = FLUSH;
          cnt_d              = CNT_W'(FLUSH_CYCLES - 1);
          exc_count_d        = exc_count_q + 16'd1;
        end else if (eret_raw) begin
          bus.flush_all      = 1'b1;
          bus.redirect_valid = 1'b1;
          bus.redirect_pc    = bus.cp0_epc;
          state_d            = FLUSH;
          cnt_d              = CNT_W'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        bus.flush_all = 1'b1;
        if (cnt_q == '0) state_d = RUN;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      exc_count_q <= '0;
      seen_d_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      exc_count_q <= exc_count_d;
      seen_d_q    <= 1'b1;
    end
  end

  assign bus.exc_count = exc_count_q;

endmodule
